// File: rtl/ifetch_queue.sv
// In-order instruction fetch queue between the PC register and decode.
// Issues one fetch per cycle, tracks in-flight requests, and drops stale responses after a redirect.
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:2] PC,
  output logic        ImReq,
  output logic [31:2] ImAddr,
  input  logic        ImGnt,
  input  logic        ImRvalid,
  input  logic [31:0] ImRdata,
  input  logic        Flush,
  output logic        Stall,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:2] InstrPC,
  input  logic        InstrReady
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [29:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PTR_W-1:0] alloc;
  logic [PTR_W-1:0] fill;
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] drop;
  // pend counts allocated entries still waiting for their response
  logic [CNT_W-1:0] pend;

  logic [CNT_W:0]   credit_sum;
  logic             req;
  logic             accept;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             rsp_any;

  // Request credit, handshake qualification and response classification.
  always_comb begin
    credit_sum = {1'b0, used} + {1'b0, drop};
    req        = 1'b0;
    accept     = 1'b0;
    pop        = 1'b0;
    rsp_drop   = 1'b0;
    rsp_fill   = 1'b0;
    if (!Flush && (used < DEPTH_C) && (credit_sum < {1'b0, DEPTH_C})) begin
      req = 1'b1;
    end else begin
      req = 1'b0;
    end
    accept = req & ImGnt;
    pop    = filled[head] & InstrReady & ~Flush;
    if (ImRvalid && (drop != CNT_ZERO)) begin
      rsp_drop = 1'b1;
    end else if (ImRvalid && (pend != CNT_ZERO)) begin
      rsp_fill = 1'b1;
    end else begin
      rsp_drop = 1'b0;
      rsp_fill = 1'b0;
    end
    rsp_any = rsp_drop | rsp_fill;
  end

  assign ImReq      = req;
  assign ImAddr     = PC;
  assign Stall      = ~accept;
  assign InstrValid = filled[head];
  assign Instr      = data_mem[head];
  assign InstrPC    = pc_mem[head];

  // Queue storage, pointers and occupancy/drop bookkeeping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= 30'h0;
        data_mem[i] <= 32'h0;
      end
      filled <= '0;
      alloc  <= '0;
      fill   <= '0;
      head   <= '0;
      used   <= '0;
      drop   <= '0;
      pend   <= '0;
    end else if (Flush) begin
      // a response arriving with the flush belongs to the old stream and is consumed here
      drop   <= drop + pend - CNT_W'(rsp_any);
      filled <= '0;
      alloc  <= '0;
      fill   <= '0;
      head   <= '0;
      used   <= '0;
      pend   <= '0;
    end else begin
      if (accept) begin
        pc_mem[alloc] <= PC;
        filled[alloc] <= 1'b0;
        alloc         <= alloc + PTR_ONE;
      end
      if (rsp_fill) begin
        data_mem[fill] <= ImRdata;
        filled[fill]   <= 1'b1;
        fill           <= fill + PTR_ONE;
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + PTR_ONE;
      end
      if (rsp_drop) begin
        drop <= drop - CNT_ONE;
      end
      case ({accept, pop})
        2'b10:   used <= used + CNT_ONE;
        2'b01:   used <= used - CNT_ONE;
        default: used <= used;
      endcase
      case ({accept, rsp_fill})
        2'b10:   pend <= pend + CNT_ONE;
        2'b01:   pend <= pend - CNT_ONE;
        default: pend <= pend;
      endcase
    end
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue sitting directly downstream of the PC register. Each cycle it issues the current PC as a request to instruction memory and tracks every accepted request in order. It collects the returned instruction words into a DEPTH-entry in-order queue and presents them to decode with a valid/ready handshake. It drives `Stall` back to the next-PC mux, so the PC register advances only when a fetch is accepted; it also discards queued and in-flight fetches on a branch redirect (`Flush`).

## Interface
- `DEPTH`, 4: queue entries and maximum outstanding memory requests; power of two, ≥2.
- `Clk` input 1: sole clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `PC` input [31:2]: current fetch word address from the PC register.
- `ImReq` output 1: fetch request valid.
- `ImAddr` output [31:2]: fetch word address; always equals `PC`.
- `ImGnt` input 1: memory accepts the request this cycle. Accept = `ImReq & ImGnt`.
- `ImRvalid` input 1: response valid. Responses return one per accepted request, in order, at least 1 cycle after acceptance.
- `ImRdata` input 32: response instruction word.
- `Flush` input 1: redirect; discard all queued and in-flight fetches.
- `Stall` output 1: next-PC mux must hold PC (NPC = PC). `Flush` has priority over `Stall` in that mux.
- `InstrValid` output 1: head entry holds a returned instruction.
- `Instr` output 32: head instruction word.
- `InstrPC` output [31:2]: word address of the head instruction.
- `InstrReady` input 1: decode consumes the head. Pop = `InstrValid & InstrReady`.

## Operation
- Storage: DEPTH entries of {pc[31:2], data[31:0], filled}. There are three pointers, each clog2(DEPTH) bits and wrapping modulo DEPTH: `alloc` (next entry to reserve), `fill` (next entry to receive a response), and `head` (next entry to pop).
- `used` is the count of allocated entries, 0..DEPTH, clog2(DEPTH)+1 bits. `drop` is the count of responses still owed for flushed requests, 0..DEPTH, same width.
- `ImReq = !Flush && used < DEPTH && (used + drop) < DEPTH`. The last term bounds total outstanding requests to DEPTH.
- On accept: the entry at `alloc` gets pc=`PC` and filled=0; `alloc` increments and `used` increments.
- `Stall = !(ImReq & ImGnt)`.
- On `ImRvalid`:
  - If `drop > 0`, decrement `drop` and write nothing.
  - Otherwise write data into the entry at `fill`, set filled=1, and increment `fill`.
- `InstrValid` = filled bit of the entry at `head`. `Instr`/`InstrPC` = data/pc of that entry.
- On pop: clear filled at `head`, increment `head`, and decrement `used`.
- Accept and pop in the same cycle leave `used` unchanged.
- On `Flush`, the outstanding count (allocated entries not yet filled) is added to `drop`. This includes any response on `ImRvalid` in the same cycle, which is treated as pre-flush and dropped. Then all filled bits are cleared, `alloc=fill=head=0`, and `used=0`. A pop in the same cycle is ignored.
- `ImRvalid` with no outstanding and `drop==0` is a protocol error: ignore it; the bench asserts it never occurs.

## Timing
- Reset values: all pointers 0; `used`=0; `drop`=0; all filled bits 0; entry pc/data 0.
  - Outputs during and after reset: `InstrValid`=0, `Instr`=0, `InstrPC`=0, `ImReq`=1 (when `Flush`=0), `Stall`=`!ImGnt`.
- Reset asserted mid-operation clears everything immediately. In-flight responses arriving after reset are not dropped; the memory is reset with the same `Reset`.
- PC advance: a request accepted in cycle t means the PC register shows PC+1 in cycle t+1.
- Response to pop: a response in cycle r gives `InstrValid`=1 in cycle r+1 (registered filled bit). There is no same-cycle bypass.
- A pop in cycle t frees credit visible to `ImReq` in t+1.
- With 1-cycle memory latency, `ImGnt`=1 and `InstrReady`=1, sustained throughput is 1 instruction/cycle.
- Full: `used==DEPTH` forces `ImReq`=0 and `Stall`=1 until a pop.
- `Flush` cycle: `ImReq`=0, and `Stall`=1 (overridden by the redirect). The first post-flush request is issued in the cycle after `Flush`.

## Test plan
- Reset then stream: PC=0x00100000, `ImGnt`=1, 1-cycle memory, `InstrReady`=1.
  - Expect `InstrPC` 0x00100000, 0x00100001, … on consecutive cycles.
  - Expect the first `InstrValid` 2 cycles after reset release, and `Stall`=0 throughout.
- Backpressure: `InstrReady`=0 with DEPTH=4.
  - Exactly 4 accepts, then `ImReq`=0 and `Stall`=1.
  - Raising `InstrReady` for one pop gives exactly one further accept the next cycle.
- Variable latency 1–5 cycles with random `ImGnt`: popped `Instr`/`InstrPC` pairs match the memory model in program order, with no loss or duplication.
- Flush with 3 outstanding requests (one response in the same cycle):
  - All 3 pre-flush responses are dropped.
  - The first popped `InstrPC` equals the redirect target.
  - `drop` returns to 0.
- Flush coinciding with a pop and full queue: `InstrValid`=0 next cycle, `used`=0, and `ImReq`=1 the cycle after `Flush`.
- Reset asserted mid-stream with 2 filled entries: `InstrValid` drops immediately (asynchronously) and outputs return to reset values.
